// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write path.
package regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG     = 5'd31;
    localparam logic [REG_ADDR_W-1:0] CLR_LAST_REG = 5'd30;

    typedef enum logic {
        SCHED_CLEAR,
        SCHED_RUN
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]                                   req,
    input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]     ptr,
    input  logic                                                 en,
    output logic [NUM_REQ-1:0]                                   grant_onehot,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0]     grant_idx
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] idx;
    logic             found;

    // Scan ptr, ptr+1, ... mod NUM_REQ and take the first valid requester.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        idx          = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found             = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register-file write port: zero-fill after reset/clear, then round-robin writeback.
module regfile_write_scheduler
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 64
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   clear_req,
    input  logic                                   stall,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]         req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic                                   wr_en,
    output logic [REG_ADDR_W-1:0]                  wr_addr,
    output logic [DATA_W-1:0]                      wr_data,
    output logic                                   clear_busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_t            state_q,   state_d;
    logic [REG_ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]        rr_ptr_q,  rr_ptr_d;
    logic                    wr_en_d;
    logic [REG_ADDR_W-1:0]   wr_addr_d;
    logic [DATA_W-1:0]       wr_data_d;

    logic                    arb_en;
    logic [NUM_REQ-1:0]      grant_onehot;
    logic [PTR_W-1:0]        grant_idx;
    logic [REG_ADDR_W-1:0]   grant_addr;

    // Grants only in RUN, and never on a stall or clear cycle.
    assign arb_en     = (state_q == SCHED_RUN) && !stall && !clear_req;
    assign req_ready  = grant_onehot;
    assign clear_busy = (state_q == SCHED_CLEAR);
    assign grant_addr = req_addr[grant_idx];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req          (req_valid),
        .ptr          (rr_ptr_q),
        .en           (arb_en),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    // State, fill counter, round-robin pointer and output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SCHED_CLEAR;
            clr_cnt_q <= '0;
            rr_ptr_q  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_en     <= wr_en_d;
            wr_addr   <= wr_addr_d;
            wr_data   <= wr_data_d;
        end
    end

    // Next-state and next-write selection; address/data hold when nothing is issued.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rr_ptr_d  = rr_ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;

        case (state_q)
            SCHED_CLEAR: begin
                if (clear_req) begin
                    clr_cnt_d = '0;
                end else if (!stall) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = clr_cnt_q;
                    wr_data_d = '0;
                    if (clr_cnt_q == CLR_LAST_REG) begin
                        state_d   = SCHED_RUN;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 5'd1;
                    end
                end
            end
            SCHED_RUN: begin
                if (clear_req) begin
                    state_d   = SCHED_CLEAR;
                    clr_cnt_d = '0;
                end else if (|grant_onehot) begin
                    // X31 writes are consumed but never reach the file.
                    wr_en_d   = (grant_addr != ZERO_REG);
                    wr_addr_d = grant_addr;
                    wr_data_d = req_data[grant_idx];
                    rr_ptr_d  = PTR_W'((32'(grant_idx) + 32'd1) % NUM_REQ);
                end
            end
            default: begin
                state_d = SCHED_CLEAR;
            end
        endcase
    end

endmodule
